// File: rtl/time_counter.sv
// time_counter: 24-hour BCD time-of-day keeper (hh:mm:ss).
// The 1 Hz divider output is handled as data on clk_in: it is synchronised,
// rising-edge detected, and each rise (with run=1) advances the time by one second.
//
// Ports:
//   clk_in      system clock
//   rst_        asynchronous active-low reset (loads init_h/init_m/init_s)
//   tick_in     1 Hz divided clock, asynchronous phase
//   run         1 = count on ticks, 0 = hold
//   load        1-cycle pulse, load set_h/set_m/set_s if legal BCD time
//   set_h/m/s   BCD time for load
//   inc_min     1-cycle pulse, minute +1 (no carry into hour)
//   inc_hour    1-cycle pulse, hour +1
//   hour_bcd/min_bcd/sec_bcd  current time, BCD
//   sec_pulse   1-cycle pulse per counted second
//   hour_chime  1-cycle pulse when a counted second rolls mm:ss to 00:00
//   load_err    1-cycle pulse when a load is rejected
module time_counter #(
  parameter logic [7:0] init_h = 8'h00,
  parameter logic [7:0] init_m = 8'h00,
  parameter logic [7:0] init_s = 8'h00
) (
  input  logic       clk_in,
  input  logic       rst_,
  input  logic       tick_in,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] set_h,
  input  logic [7:0] set_m,
  input  logic [7:0] set_s,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       sec_pulse,
  output logic       hour_chime,
  output logic       load_err
);

  localparam logic [7:0] MAX_H  = 8'h23;
  localparam logic [7:0] MAX_MS = 8'h59;

  // BCD increment with wrap at maxv; bit 8 of the result flags the wrap.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
    logic [8:0] r;
    if (v == maxv)
      r = {1'b1, 8'h00};
    else if (v[3:0] == 4'h9)
      r = {1'b0, v[7:4] + 4'd1, 4'h0};
    else
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Legal BCD value: both nibbles decimal and not above maxv.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] maxv);
    return (v[7:4] <= 4'h9) && (v[3:0] <= 4'h9) && (v <= maxv);
  endfunction

  logic       s1, s2, s3;
  logic       rise;
  logic       load_ok;
  logic [8:0] s_inc, m_inc, h_inc;
  logic [7:0] h_nxt, m_nxt, s_nxt;
  logic       sp_nxt, ch_nxt, err_nxt;

  assign rise    = s2 & ~s3;
  assign load_ok = bcd_ok(set_h, MAX_H) && bcd_ok(set_m, MAX_MS) && bcd_ok(set_s, MAX_MS);
  assign s_inc   = bcd_inc(sec_bcd, MAX_MS);
  assign m_inc   = bcd_inc(min_bcd, MAX_MS);
  assign h_inc   = bcd_inc(hour_bcd, MAX_H);

  // Tick synchroniser; preset high so a tick already high at reset release is ignored.
  always_ff @(posedge clk_in or negedge rst_) begin
    if (!rst_) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Next-state: one event per cycle, load > inc_hour > inc_min > tick.
  always_comb begin
    h_nxt   = hour_bcd;
    m_nxt   = min_bcd;
    s_nxt   = sec_bcd;
    sp_nxt  = 1'b0;
    ch_nxt  = 1'b0;
    err_nxt = 1'b0;
    if (load) begin
      if (load_ok) begin
        h_nxt = set_h;
        m_nxt = set_m;
        s_nxt = set_s;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (inc_hour) begin
      h_nxt = h_inc[7:0];
    end else if (inc_min) begin
      m_nxt = m_inc[7:0];
    end else if (rise && run) begin
      s_nxt  = s_inc[7:0];
      sp_nxt = 1'b1;
      if (s_inc[8]) begin
        m_nxt = m_inc[7:0];
        if (m_inc[8]) begin
          h_nxt  = h_inc[7:0];
          ch_nxt = 1'b1;
        end
      end
    end
  end

  // Time and pulse registers.
  always_ff @(posedge clk_in or negedge rst_) begin
    if (!rst_) begin
      hour_bcd   <= init_h;
      min_bcd    <= init_m;
      sec_bcd    <= init_s;
      sec_pulse  <= 1'b0;
      hour_chime <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      hour_bcd   <= h_nxt;
      min_bcd    <= m_nxt;
      sec_bcd    <= s_nxt;
      sec_pulse  <= sp_nxt;
      hour_chime <= ch_nxt;
      load_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: directed bench for time_counter with a command vector
// table plus hand-written multi-cycle tick sequences.
module tb_time_counter;

  logic       clk_in = 1'b0;
  logic       rst_;
  logic       tick_in, run, load, inc_min, inc_hour;
  logic [7:0] set_h, set_m, set_s;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic       sec_pulse, hour_chime, load_err;

  int checks = 0;
  int errors = 0;
  int sp_cnt = 0;

  time_counter dut (
    .clk_in    (clk_in),
    .rst_      (rst_),
    .tick_in   (tick_in),
    .run       (run),
    .load      (load),
    .set_h     (set_h),
    .set_m     (set_m),
    .set_s     (set_s),
    .inc_min   (inc_min),
    .inc_hour  (inc_hour),
    .hour_bcd  (hour_bcd),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .sec_pulse (sec_pulse),
    .hour_chime(hour_chime),
    .load_err  (load_err)
  );

  always #10 clk_in = ~clk_in;

  always @(negedge clk_in) if (sec_pulse) sp_cnt++;

  typedef struct {
    logic       ld;
    logic [7:0] sh, sm, ss;
    logic       im, ih;
    logic [7:0] eh, em, es;
    logic       eerr;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_time(input string name, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    chk({name, " time"}, {8'h00, hour_bcd, min_bcd, sec_bcd}, {8'h00, h, m, s});
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    load = 1'b1; set_h = h; set_m = m; set_s = s;
    step();
    load = 1'b0;
    step();
  endtask

  // Full counted tick: check the update lands on the 3rd edge, then drop tick_in.
  task automatic tick_check(input string name, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s, input logic chime);
    tick_in = 1'b1;
    step(); step(); step();
    chk_time(name, h, m, s);
    chk({name, " sec_pulse"}, 32'(sec_pulse), 32'd1);
    chk({name, " hour_chime"}, 32'(hour_chime), 32'(chime));
    step();
    chk({name, " pulses clear"}, {30'd0, sec_pulse, hour_chime}, 32'd0);
    tick_in = 1'b0;
    step(); step(); step();
  endtask

  initial begin
    int sp0;
    // ld   sh     sm     ss    im    ih    eh     em     es    err
    vecs[0]  = '{1'b1, 8'h23, 8'h59, 8'h58, 1'b0, 1'b0, 8'h23, 8'h59, 8'h58, 1'b0};
    vecs[1]  = '{1'b1, 8'h24, 8'h00, 8'h00, 1'b0, 1'b0, 8'h23, 8'h59, 8'h58, 1'b1};
    vecs[2]  = '{1'b1, 8'h12, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h23, 8'h59, 8'h58, 1'b1};
    vecs[3]  = '{1'b1, 8'h1A, 8'h00, 8'h00, 1'b0, 1'b0, 8'h23, 8'h59, 8'h58, 1'b1};
    vecs[4]  = '{1'b1, 8'h10, 8'h59, 8'h30, 1'b0, 1'b0, 8'h10, 8'h59, 8'h30, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 8'h30, 1'b0};
    vecs[6]  = '{1'b1, 8'h23, 8'h15, 8'h00, 1'b0, 1'b0, 8'h23, 8'h15, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h15, 8'h00, 1'b0};
    vecs[8]  = '{1'b1, 8'h09, 8'h09, 8'h09, 1'b0, 1'b0, 8'h09, 8'h09, 8'h09, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h09, 8'h10, 8'h09, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h10, 8'h10, 8'h09, 1'b0};
    vecs[11] = '{1'b1, 8'h05, 8'h06, 8'h07, 1'b1, 1'b1, 8'h05, 8'h06, 8'h07, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h06, 8'h06, 8'h07, 1'b0};
    vecs[13] = '{1'b1, 8'h00, 8'h00, 8'h5F, 1'b0, 1'b0, 8'h06, 8'h06, 8'h07, 1'b1};

    rst_ = 1'b0; tick_in = 1'b1; run = 1'b1; load = 1'b0;
    inc_min = 1'b0; inc_hour = 1'b0; set_h = 8'h00; set_m = 8'h00; set_s = 8'h00;
    step(); step();
    chk_time("reset", 8'h00, 8'h00, 8'h00);
    chk("reset pulses", {29'd0, sec_pulse, hour_chime, load_err}, 32'd0);

    // Release with tick_in already high: must not count.
    rst_ = 1'b1;
    repeat (100) step();
    chk_time("tick high at release", 8'h00, 8'h00, 8'h00);
    chk("no sec_pulse after release", 32'(sp_cnt), 32'd0);

    // First real tick: latency and single pulse, long high level counts once.
    tick_in = 1'b0;
    repeat (4) step();
    tick_in = 1'b1;
    step();
    chk_time("latency edge1", 8'h00, 8'h00, 8'h00);
    step();
    chk_time("latency edge2", 8'h00, 8'h00, 8'h00);
    chk("latency edge2 pulse", 32'(sec_pulse), 32'd0);
    step();
    chk_time("latency edge3", 8'h00, 8'h00, 8'h01);
    chk("latency edge3 pulse", 32'(sec_pulse), 32'd1);
    step();
    chk("pulse width", 32'(sec_pulse), 32'd0);
    repeat (20) step();
    chk_time("long high one rise", 8'h00, 8'h00, 8'h01);
    chk("long high pulse count", 32'(sp_cnt), 32'd1);
    tick_in = 1'b0;
    repeat (3) step();

    // Command vector table (no ticks).
    for (int i = 0; i < 14; i++) begin
      load = vecs[i].ld; set_h = vecs[i].sh; set_m = vecs[i].sm; set_s = vecs[i].ss;
      inc_min = vecs[i].im; inc_hour = vecs[i].ih;
      step();
      load = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
      chk_time($sformatf("vec%0d", i), vecs[i].eh, vecs[i].em, vecs[i].es);
      chk($sformatf("vec%0d load_err", i), 32'(load_err), 32'(vecs[i].eerr));
      chk($sformatf("vec%0d no tick pulses", i), {30'd0, sec_pulse, hour_chime}, 32'd0);
      step();
      chk($sformatf("vec%0d load_err clear", i), 32'(load_err), 32'd0);
    end

    // Day rollover with hour chime on the second tick only.
    do_load(8'h23, 8'h59, 8'h58);
    tick_check("to 23:59:59", 8'h23, 8'h59, 8'h59, 1'b0);
    tick_check("to 00:00:00", 8'h00, 8'h00, 8'h00, 1'b1);

    // Nibble carries through all three fields.
    do_load(8'h09, 8'h59, 8'h59);
    tick_check("to 10:00:00", 8'h10, 8'h00, 8'h00, 1'b1);
    do_load(8'h00, 8'h00, 8'h59);
    tick_check("to 00:01:00", 8'h00, 8'h01, 8'h00, 1'b0);

    // inc_min coincident with rise: tick is discarded, not deferred.
    do_load(8'h00, 8'h00, 8'h09);
    sp0 = sp_cnt;
    tick_in = 1'b1;
    step(); step();
    inc_min = 1'b1;
    step();
    inc_min = 1'b0;
    chk_time("inc_min beats tick", 8'h00, 8'h01, 8'h09);
    chk("inc_min beats tick pulse", 32'(sec_pulse), 32'd0);
    repeat (5) step();
    tick_in = 1'b0;
    repeat (3) step();
    chk_time("discarded tick lost", 8'h00, 8'h01, 8'h09);
    chk("discarded tick no pulse", 32'(sp_cnt - sp0), 32'd0);

    // run=0 freezes time across ticks.
    run = 1'b0;
    sp0 = sp_cnt;
    for (int k = 0; k < 3; k++) begin
      tick_in = 1'b1; repeat (4) step();
      tick_in = 1'b0; repeat (4) step();
    end
    chk_time("run=0 frozen", 8'h00, 8'h01, 8'h09);
    chk("run=0 no pulses", 32'(sp_cnt - sp0), 32'd0);
    run = 1'b1;

    // Asynchronous reset with a rise pending.
    do_load(8'h12, 8'h34, 8'h56);
    tick_in = 1'b1;
    step(); step();
    rst_ = 1'b0;
    #2;
    chk_time("async reset", 8'h00, 8'h00, 8'h00);
    step();
    rst_ = 1'b1;
    repeat (10) step();
    chk_time("pending rise dropped", 8'h00, 8'h00, 8'h00);
    tick_in = 1'b0;
    repeat (3) step();
    tick_check("count after reset", 8'h00, 8'h00, 8'h01, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
